// File: rtl/rv_pkg.sv
// Shared header for the fetch-stage slice.
// Holds the reset PC and bubble encoding defaults, the fetch FSM state type,
// and a word-alignment helper used on redirect targets.
package rv_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched {pc, inst} pair.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   clear           drop the held entry (takes priority over push/pop)
//   push            capture push_pc/push_inst, mark full
//   pop             release the held entry
//   push_pc/inst    incoming pair
//   full            an entry is held
//   pc/inst         held pair
module if_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc   <= 32'd0;
      inst <= 32'd0;
    end else if (push) begin
      pc   <= push_pc;
      inst <= push_inst;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, fetches over a req/gnt/rvalid handshake with at most one
// request outstanding, and presents {if_pc, if_inst, if_valid} every cycle
// (a NOP bubble when nothing is ready). Honours stall and EX redirect.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   if_stall                 downstream is not consuming this cycle
//   redirect_en/redirect_pc  flush and restart fetch at redirect_pc (aligned)
//   imem_req/imem_addr       fetch request (combinational from state)
//   imem_gnt                 request accepted
//   imem_rvalid/imem_rdata   in-order response, one per grant
//   if_pc/if_inst/if_valid   registered output to IF/ID
//
// state  | meaning
// S_IDLE | first cycle after reset, no request
// S_REQ  | request driven (unless skid full), waiting for gnt
// S_WAIT | granted, response will be delivered
// S_DROP | granted, response belongs to a flushed path and is discarded
module if_fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pc_d, inst_d;
  logic         valid_d;

  logic         skid_full, skid_push, skid_pop;
  logic [31:0]  skid_pc, skid_inst;

  logic         handshake;
  logic         resp_live;
  logic [31:0]  resp_pc;
  logic [31:0]  redirect_tgt;

  assign imem_req     = (state_q == S_REQ) && !skid_full;
  assign imem_addr    = fetch_pc_q;
  assign handshake    = imem_req && imem_gnt;
  assign redirect_tgt = align_word(redirect_pc);

  // In S_WAIT fetch_pc has already been advanced past the granted address,
  // so the response's PC is one word behind it.
  assign resp_pc   = fetch_pc_q - 32'd4;
  assign resp_live = imem_rvalid && (state_q == S_WAIT) && !redirect_en;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (handshake) begin
          state_d    = S_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT: if (imem_rvalid) state_d = S_REQ;
      S_DROP: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    if (redirect_en) begin
      fetch_pc_d = redirect_tgt;
      case (state_q)
        S_REQ:  state_d = handshake ? S_DROP : S_REQ;
        // A response landing with the redirect retires the outstanding
        // request, so there is nothing left to drop.
        S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    pc_d      = if_pc;
    inst_d    = if_inst;
    valid_d   = if_valid;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    if (redirect_en) begin
      pc_d    = 32'd0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!if_stall) begin
      if (skid_full) begin
        pc_d     = skid_pc;
        inst_d   = skid_inst;
        valid_d  = 1'b1;
        skid_pop = 1'b1;
      end else if (resp_live) begin
        pc_d    = resp_pc;
        inst_d  = imem_rdata;
        valid_d = 1'b1;
      end else begin
        pc_d    = 32'd0;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end else if (resp_live) begin
      // Skid cannot already be full here: requests stop while it is occupied.
      skid_push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      if_pc      <= 32'd0;
      if_inst    <= NOP_INST;
      if_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_pc      <= pc_d;
      if_inst    <= inst_d;
      if_valid   <= valid_d;
    end
  end

  if_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_en),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_pc   (resp_pc),
    .push_inst (imem_rdata),
    .full      (skid_full),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, if_stall, redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_stall    (if_stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  int consumed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference: consumed instructions form the sequential program starting at
  // the last reset PC or redirect target.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;
  fetch_t      exp_q[$];
  logic [31:0] next_pc;

  // Memory responder state
  bit          pend = 0, pend_stale = 0, pend_orphan = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  int          gnt_pct = 100, lat_lo = 0, lat_hi = 0;

  bit          prev_req = 0, prev_gnt = 0, prev_redir = 0;
  logic [31:0] prev_addr = 32'd0;

  // Inputs as seen by the DUT at the most recent active edge
  logic edge_rst = 1'b0, edge_redir = 1'b0, edge_stall = 1'b0;
  always @(posedge clk) begin
    edge_rst   <= rst;
    edge_redir <= redirect_en;
    edge_stall <= if_stall;
  end

  // Called at a negedge: checks request protocol, plays memory, drives the
  // inputs for the next edge, then waits for the following negedge.
  task automatic cycle(input bit stall, input bit redir, input logic [31:0] tgt);
    bit          rv, g;
    logic [31:0] rd;
    if (imem_req) chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
    if (pend && !pend_orphan) chk("req_while_outstanding", {31'd0, imem_req}, 32'd0);
    if (prev_req && !prev_gnt && !prev_redir) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (redir && pend) pend_stale = 1;
    rv = 0; g = 0; rd = 32'd0;
    if (pend) begin
      if (pend_cnt == 0) begin
        rv = 1;
        rd = pend_stale ? STALE : mem_word(pend_addr);
        pend = 0;
        pend_orphan = 0;
      end else begin
        pend_cnt--;
      end
    end else if (imem_req && ($urandom_range(99) < gnt_pct)) begin
      g = 1;
      pend = 1;
      pend_stale = redir;
      pend_orphan = 0;
      pend_addr = imem_addr;
      pend_cnt = $urandom_range(lat_hi, lat_lo);
    end
    if (redir) begin
      exp_q.delete();
      next_pc = tgt & ~32'd3;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc += 32'd4;
    end
    if_stall    = stall;
    redirect_en = redir;
    redirect_pc = tgt;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    prev_req    = imem_req;
    prev_gnt    = g;
    prev_redir  = redir;
    prev_addr   = imem_addr;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      rst = 0; if_stall = 0; redirect_en = 0; redirect_pc = 32'd0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'd0;
      @(negedge clk);
    end
    // The memory still answers a request the DUT has forgotten.
    if (pend) begin
      pend_orphan = 1;
      pend_stale  = 1;
      pend_cnt    = 0;
    end
    exp_q.delete();
    next_pc  = RST_PC;
    prev_req = 0;
    rst = 1;
  endtask

  // Monitor / scoreboard
  initial begin
    fetch_t      e;
    logic [31:0] hold_pc = 32'd0, hold_inst = 32'd0;
    logic        hold_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!edge_rst) begin
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
      end else if (edge_redir) begin
        chk("redirect_bubble", {31'd0, if_valid}, 32'd0);
      end else if (edge_stall) begin
        chk("stall_hold_pc", if_pc, hold_pc);
        chk("stall_hold_inst", if_inst, hold_inst);
        chk("stall_hold_valid", {31'd0, if_valid}, {31'd0, hold_v});
      end
      if (!if_valid) begin
        chk("bubble_pc", if_pc, 32'd0);
        chk("bubble_inst", if_inst, NOP);
      end
      if (rst && !redirect_en && !if_stall && if_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL fetch_seq: got pc %h with nothing expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_pc", if_pc, e.pc);
          chk("fetch_inst", if_inst, e.inst);
          consumed++;
        end
      end
      hold_pc = if_pc; hold_inst = if_inst; hold_v = if_valid;
    end
  end

  initial begin
    rst = 0; if_stall = 0; redirect_en = 0; redirect_pc = 32'd0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'd0;
    next_pc = RST_PC;
    @(negedge clk);

    // Reset and straight-line fetch, 1-cycle latency
    gnt_pct = 100; lat_lo = 0; lat_hi = 0;
    do_reset(2);
    chk("t1_req_idle", {31'd0, imem_req}, 32'd0);
    cycle(0, 0, 32'd0);
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, RST_PC);
    cycle(0, 0, 32'd0);
    cycle(0, 0, 32'd0);
    chk("t2_valid0", {31'd0, if_valid}, 32'd1);
    chk("t2_pc0", if_pc, RST_PC);
    chk("t2_inst0", if_inst, mem_word(RST_PC));
    cycle(0, 0, 32'd0);
    chk("t2_bubble", {31'd0, if_valid}, 32'd0);
    cycle(0, 0, 32'd0);
    chk("t2_valid1", {31'd0, if_valid}, 32'd1);
    chk("t2_pc1", if_pc, RST_PC + 32'd4);

    // Stall while a response arrives: skid fills, requests stop
    cycle(1, 0, 32'd0);
    cycle(1, 0, 32'd0);
    chk("t3_req_off", {31'd0, imem_req}, 32'd0);
    chk("t3_hold_pc", if_pc, RST_PC + 32'd4);
    cycle(1, 0, 32'd0);
    chk("t3_req_off2", {31'd0, imem_req}, 32'd0);
    cycle(0, 0, 32'd0);
    chk("t3_skid_pc", if_pc, RST_PC + 32'd8);
    chk("t3_skid_valid", {31'd0, if_valid}, 32'd1);
    chk("t3_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t3_resume_addr", imem_addr, RST_PC + 32'd12);

    // Redirect while waiting; the late response carries stale data
    lat_lo = 2; lat_hi = 2;
    cycle(0, 0, 32'd0);
    cycle(0, 1, 32'h8000_0102);
    chk("t4_bubble", {31'd0, if_valid}, 32'd0);
    chk("t4_req_drop", {31'd0, imem_req}, 32'd0);
    lat_lo = 0; lat_hi = 0;
    cycle(0, 0, 32'd0);
    cycle(0, 0, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h8000_0100);

    // Redirect together with stall while the skid is full
    cycle(0, 0, 32'd0);
    cycle(0, 0, 32'd0);
    chk("t5_pc", if_pc, 32'h8000_0100);
    cycle(1, 0, 32'd0);
    cycle(1, 0, 32'd0);
    chk("t5_skid_full_req", {31'd0, imem_req}, 32'd0);
    cycle(1, 1, 32'h8000_0200);
    chk("t5_bubble", {31'd0, if_valid}, 32'd0);
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h8000_0200);
    for (int k = 0; k < 6; k++) cycle(0, 0, 32'd0);

    // Reset while a request is outstanding; its response arrives afterwards
    lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 10 && !pend; k++) cycle(0, 0, 32'd0);
    chk("t6_granted", {31'd0, pend}, 32'd1);
    cycle(0, 0, 32'd0);
    do_reset(2);
    cycle(0, 0, 32'd0);
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr", imem_addr, RST_PC);
    lat_lo = 0; lat_hi = 0;
    for (int k = 0; k < 8; k++) cycle(0, 0, 32'd0);

    // Randomised traffic
    gnt_pct = 60; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      bit          s, r;
      logic [31:0] t;
      s = ($urandom_range(99) < 25);
      r = ($urandom_range(99) < 3);
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else                        t = RST_PC + 32'($urandom_range(4095));
      if (i == 2000) do_reset(2);
      cycle(s, r, t);
    end
    for (int k = 0; k < 10; k++) cycle(0, 0, 32'd0);
    chk("progress", {31'd0, consumed > 300}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
